// File: rtl/exhaustive_checker.sv
// exhaustive_checker
//   Walks a stimulus vector through every value 0 .. 2^IN_W-1. For each
//   vector it waits SETTLE cycles, then compares dut_y with gold_y for one
//   cycle. It counts mismatches (saturating) and captures the stim value of
//   the first mismatch.
//
//   Optional feature: define EXHAUSTIVE_CHECKER_STOP_ON_FAIL_EN to end the
//   sweep at the first mismatch instead of covering every vector.
//
// Ports
//   clk       in   single clock, rising edge
//   rst_n     in   synchronous active-low reset
//   start     in   one-cycle sweep request, honoured only in IDLE
//   stim      out  [IN_W]  stimulus vector to the DUT and the golden model
//   dut_y     in   [OUT_W] DUT response
//   gold_y    in   [OUT_W] expected response
//   busy      out  high through the SETTLE/CHECK cycles of a sweep
//   done      out  one-cycle pulse in the DONE state
//   pass      out  last completed sweep had no mismatch; held until next start
//   err_cnt   out  [ERR_W] saturating mismatch count
//   ff_valid  out  a first-failure vector has been captured
//   ff_vec    out  [IN_W]  stim value of the first mismatch
//   dbg_state out  [2]     current FSM state (IDLE=0, SETTLE=1, CHECK=2, DONE=3)
//
// Handshake: start is a level sampled on each rising edge while in IDLE.
// There is no ready; a start seen outside IDLE is dropped, never queued.
module exhaustive_checker #(
  parameter int IN_W   = 3,
  parameter int OUT_W  = 1,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [IN_W-1:0]  stim,
  input  logic [OUT_W-1:0] dut_y,
  input  logic [OUT_W-1:0] gold_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             ff_valid,
  output logic [IN_W-1:0]  ff_vec,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [IN_W-1:0]  STIM_LAST   = '1;
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;
  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IN_W-1:0]  stim_q, stim_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             ffv_q, ffv_d;
  logic [IN_W-1:0]  ffvec_q, ffvec_d;
  logic             pass_q, pass_d;

  logic mismatch;
  logic stop_now;

  assign mismatch = (dut_y != gold_y);

`ifdef EXHAUSTIVE_CHECKER_STOP_ON_FAIL_EN
  assign stop_now = mismatch;
`else
  assign stop_now = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stim_d  = stim_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffvec_d = ffvec_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
          stim_d  = '0;
          err_d   = '0;
          ffv_d   = 1'b0;
          ffvec_d = '0;
          pass_d  = 1'b0;
        end
      end
      S_SETTLE: begin
        // cnt counts settle cycles already spent on this vector
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_CHECK: begin
        cnt_d = '0;
        if (mismatch) begin
          if (err_q != ERR_MAX) begin
            err_d = err_q + 1'b1;
          end
          if (!ffv_q) begin
            ffv_d   = 1'b1;
            ffvec_d = stim_q;
          end
        end
        // pass is decided from the count including this final compare
        if (stop_now || (stim_q == STIM_LAST)) begin
          state_d = S_DONE;
          pass_d  = (err_d == '0);
        end else begin
          state_d = S_SETTLE;
          stim_d  = stim_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      stim_q  <= '0;
      err_q   <= '0;
      ffv_q   <= 1'b0;
      ffvec_q <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stim_q  <= stim_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffvec_q <= ffvec_d;
      pass_q  <= pass_d;
    end
  end

  assign stim      = stim_q;
  assign busy      = (state_q == S_SETTLE) || (state_q == S_CHECK);
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;
  assign err_cnt   = err_q;
  assign ff_valid  = ffv_q;
  assign ff_vec    = ffvec_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_exhaustive_checker.sv
module tb_exhaustive_checker;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- default-parameter instance ----------------
  logic       start = 1'b0;
  logic [2:0] stim;
  logic [0:0] dut_y, gold_y;
  logic       busy, done, pass, ff_valid;
  logic [7:0] err_cnt;
  logic [2:0] ff_vec;
  logic [1:0] dbg_state;
  logic [7:0] mask = 8'h00;

  // Reference response is an arbitrary function of stim; mask bit n makes
  // the DUT response wrong for stim == n.
  always_comb begin
    gold_y = stim[0] ^ stim[2];
    dut_y  = gold_y ^ mask[stim];
  end

  exhaustive_checker u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stim(stim),
    .dut_y(dut_y), .gold_y(gold_y), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .ff_valid(ff_valid), .ff_vec(ff_vec),
    .dbg_state(dbg_state)
  );

  // ---------------- small instance for saturation ----------------
  logic       start2 = 1'b0;
  logic [1:0] stim2;
  logic [0:0] dut2, gold2;
  logic       busy2, done2, pass2, ffv2;
  logic [1:0] err2;
  logic [1:0] ffvec2;
  logic [1:0] dbg2;

  always_comb begin
    gold2 = stim2[1];
    dut2  = ~gold2;
  end

  exhaustive_checker #(.IN_W(2), .OUT_W(1), .SETTLE(1), .ERR_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start2), .stim(stim2),
    .dut_y(dut2), .gold_y(gold2), .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(err2), .ff_valid(ffv2), .ff_vec(ffvec2), .dbg_state(dbg2)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] mask;
    int         exp_err;
    int         exp_ffv;
    int         exp_vec;
    int         exp_pass;
    int         exp_len;
    int         exp_stim;
  } vec_t;

  vec_t tbl[5];

  // ---------------- driver tasks ----------------
  // Pulses start, then counts cycles from the first SETTLE cycle (0) until
  // done is seen. Optionally re-asserts start while stim == pulse_at.
  task automatic run_sweep(input int pulse_at, output int len);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    len = -1;
    for (int k = 0; k < 200; k++) begin
      if (k == 0) begin
        check("busy_first_settle", 32'(busy), 32'd1);
        check("stim_first_settle", 32'(stim), 32'd0);
      end
      start = (pulse_at >= 0) && (k > 0) && (int'(stim) == pulse_at);
      if (done) begin
        len = k;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic do_entry(input int i, input int pulse_at);
    int len;
    mask = tbl[i].mask;
    run_sweep(pulse_at, len);
    check($sformatf("len[%0d]", i), 32'(len), 32'(tbl[i].exp_len));
    check($sformatf("busy_done[%0d]", i), 32'(busy), 32'd0);
    check($sformatf("err_cnt[%0d]", i), 32'(err_cnt), 32'(tbl[i].exp_err));
    check($sformatf("ff_valid[%0d]", i), 32'(ff_valid), 32'(tbl[i].exp_ffv));
    check($sformatf("ff_vec[%0d]", i), 32'(ff_vec), 32'(tbl[i].exp_vec));
    check($sformatf("pass[%0d]", i), 32'(pass), 32'(tbl[i].exp_pass));
    @(negedge clk);
    check($sformatf("done_pulse[%0d]", i), 32'(done), 32'd0);
    check($sformatf("pass_hold[%0d]", i), 32'(pass), 32'(tbl[i].exp_pass));
    check($sformatf("stim_hold[%0d]", i), 32'(stim), 32'(tbl[i].exp_stim));
  endtask

  // ---------------- test ----------------
  initial begin
    int len;
    int saw_done;

`ifdef EXHAUSTIVE_CHECKER_STOP_ON_FAIL_EN
    tbl[0] = '{8'h00, 0, 0, 0, 1, 16, 7};
    tbl[1] = '{8'h48, 1, 1, 3, 0,  8, 3};
    tbl[2] = '{8'h04, 1, 1, 2, 0,  6, 2};
    tbl[3] = '{8'hFF, 1, 1, 0, 0,  2, 0};
    tbl[4] = '{8'h80, 1, 1, 7, 0, 16, 7};
`else
    tbl[0] = '{8'h00, 0, 0, 0, 1, 16, 7};
    tbl[1] = '{8'h48, 2, 1, 3, 0, 16, 7};
    tbl[2] = '{8'h04, 1, 1, 2, 0, 16, 7};
    tbl[3] = '{8'hFF, 8, 1, 0, 0, 16, 7};
    tbl[4] = '{8'h80, 1, 1, 7, 0, 16, 7};
`endif

    // reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_err", 32'(err_cnt), 32'd0);
    check("rst_stim", 32'(stim), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // table-driven sweeps
    for (int i = 0; i < 5; i++) do_entry(i, -1);

    // start re-pulsed at stim == 5 must be ignored
    do_entry(1, 5);

    // reset mid-sweep while stim == 4 in SETTLE
    mask = 8'h04;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (stim == 3'd4) break;
      @(negedge clk);
    end
    check("abort_stim4", 32'(stim), 32'd4);
    check("abort_in_settle", 32'(dbg_state), 32'd1);
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_pass", 32'(pass), 32'd0);
    check("abort_err", 32'(err_cnt), 32'd0);
    check("abort_ffv", 32'(ff_valid), 32'd0);
    check("abort_ffvec", 32'(ff_vec), 32'd0);
    check("abort_stim", 32'(stim), 32'd0);
    saw_done = 0;
    for (int k = 0; k < 30; k++) begin
      if (done || busy) saw_done++;
      @(negedge clk);
    end
    check("abort_no_done", 32'(saw_done), 32'd0);
    mask = 8'h00;
    run_sweep(-1, len);
    check("fresh_len", 32'(len), 32'd16);
    check("fresh_pass", 32'(pass), 32'd1);

    // saturation on the 2-bit instance: 4 mismatches, counter caps at 3
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    len = -1;
    for (int k = 0; k < 100; k++) begin
      if (done2) begin
        len = k;
        break;
      end
      @(negedge clk);
    end
`ifdef EXHAUSTIVE_CHECKER_STOP_ON_FAIL_EN
    check("sat_len", 32'(len), 32'd2);
    check("sat_err", 32'(err2), 32'd1);
`else
    check("sat_len", 32'(len), 32'd8);
    check("sat_err", 32'(err2), 32'd3);
`endif
    check("sat_pass", 32'(pass2), 32'd0);
    check("sat_ffvec", 32'(ffvec2), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/exhaustive_checker.md
EXHAUSTIVE_CHECKER -- requirements
Module: exhaustive_checker

Interface
REQ-001 The block SHALL have parameter IN_W, default 3: width of the stimulus vector driven to the DUT.
REQ-002 The block SHALL have parameter OUT_W, default 1: width of the DUT response and of the golden response.
REQ-003 The block SHALL have parameter SETTLE, default 1, legal range 1..15: number of settle cycles allowed per vector before compare.
REQ-004 The block SHALL have parameter ERR_W, default 8: width of the error counter.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 start  input  1  single-cycle request to run one full sweep; sampled only in IDLE.
REQ-008 stim  output  IN_W  stimulus vector to the DUT and the golden model.
REQ-009 dut_y  input  OUT_W  DUT response to stim.
REQ-010 gold_y  input  OUT_W  expected response to stim.
REQ-011 busy  output  1  high from the cycle after start is accepted until the last CHECK cycle, inclusive.
REQ-012 done  output  1  one-cycle pulse at sweep end.
REQ-013 pass  output  1  high when the last completed sweep had zero mismatches; held until the next start.
REQ-014 err_cnt  output  ERR_W  mismatch count of the current or last sweep.
REQ-015 ff_valid  output  1  high once a mismatch has been captured in the current or last sweep.
REQ-016 ff_vec  output  IN_W  stim value of the first mismatch.

Function
REQ-017 FSM states SHALL be IDLE, SETTLE, CHECK, DONE; encoding is free.
REQ-018 IDLE with start=1: go to SETTLE, set stim=0, clear err_cnt, ff_valid, ff_vec and pass, set busy=1.
REQ-019 SETTLE: hold stim stable for exactly SETTLE cycles, then go to CHECK.
REQ-020 CHECK (one cycle): mismatch = (dut_y != gold_y) on all OUT_W bits; on mismatch, increment err_cnt; on the first mismatch, also load ff_vec=stim and set ff_valid=1.
REQ-021 CHECK with stim != 2^IN_W-1: stim increments by 1 and the FSM returns to SETTLE.
REQ-022 CHECK with stim == 2^IN_W-1: go to DONE; stim does not wrap.
REQ-023 Each vector SHALL occupy exactly SETTLE+1 cycles; the sweep SHALL occupy 2^IN_W*(SETTLE+1) cycles from the first SETTLE cycle to the last CHECK cycle.
REQ-024 DONE (one cycle): done=1, busy=0, pass=(err_cnt==0), then go to IDLE.
REQ-025 err_cnt SHALL saturate at 2^ERR_W-1 and never wrap.
REQ-026 start while not in IDLE SHALL be ignored; no queueing.
REQ-027 stim SHALL hold its last value in IDLE; results SHALL hold until the next accepted start.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force IDLE, stim=0, busy=0, done=0, pass=0, err_cnt=0, ff_valid=0, ff_vec=0, from any state including mid-sweep.
REQ-029 A sweep aborted by reset SHALL NOT produce done; a new start is required.

Configuration
REQ-030 With macro EXHAUSTIVE_CHECKER_STOP_ON_FAIL_EN defined: a mismatch in CHECK SHALL go directly to DONE (pass=0, err_cnt=1, ff_vec=failing stim) without visiting later vectors.
REQ-031 Without EXHAUSTIVE_CHECKER_STOP_ON_FAIL_EN: the sweep SHALL always cover all 2^IN_W vectors, as in REQ-021/022.

Verification
REQ-032 Defaults, gold_y tied to dut_y, start pulse -> done exactly 16 cycles after the first SETTLE cycle; pass=1, err_cnt=0, ff_valid=0.
REQ-033 Defaults, dut_y wrong for stim=3'b011 and 3'b110 only -> err_cnt=2, ff_vec=3'b011, ff_valid=1, pass=0.
REQ-034 IN_W=2, ERR_W=2, every vector mismatched -> err_cnt saturates at 3; done after 8 cycles.
REQ-035 rst_n low for 1 cycle while stim=4 during SETTLE -> all outputs at reset values next cycle, no done; a fresh start runs a full 16-cycle sweep from stim=0.
REQ-036 Start pulsed again at stim=5 mid-sweep -> ignored; sweep length and results unchanged.
REQ-037 STOP_ON_FAIL_EN defined, mismatch only at stim=2 (SETTLE=1) -> done 6 cycles after the first SETTLE cycle, err_cnt=1, ff_vec=2, pass=0.
